// File: rtl/rv32ima_soc_pkg.sv
// Shared constants for the rv32ima SoC slice: enable polarities, bus widths,
// default memory map and the RV32I major opcodes used by the core.
package rv32ima_soc_pkg;

   localparam logic RST_ENABLE   = 1'b1;
   localparam logic RST_DISABLE  = 1'b0;
   localparam logic CHIP_ENABLE  = 1'b1;
   localparam logic CHIP_DISABLE = 1'b0;
   localparam logic WRITE_ENABLE = 1'b1;

   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

   localparam int INST_BUS_W      = 32;
   localparam int INST_ADDR_BUS_W = 32;

   localparam logic [31:0] RAM_BASE_DEF  = 32'h1000_0000;
   localparam logic [31:0] HALT_ADDR_DEF = 32'h2000_0000;

   typedef enum logic [6:0] {
      OPC_LUI   = 7'b0110111,
      OPC_AUIPC = 7'b0010111,
      OPC_JAL   = 7'b1101111,
      OPC_OPIMM = 7'b0010011,
      OPC_LOAD  = 7'b0000011,
      OPC_STORE = 7'b0100011
   } opcode_t;

endpackage

// File: rtl/rv32ima_core.sv
// Compact single-cycle implementation of the rv32ima_core port contract.
// Executes LUI, AUIPC, JAL, OP-IMM, LW and SB/SH/SW. A stall freezes PC and
// register file and withdraws the data-port request.
module rv32ima_core
   import rv32ima_soc_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   output logic [31:0] rom_addr_o,
   output logic        rom_ce_o,
   input  logic [31:0] rom_data_i,
   output logic [31:0] ram_addr_o,
   output logic        ram_ce_o,
   output logic        ram_we_o,
   output logic [3:0]  ram_sel_o,
   output logic [31:0] ram_data_o,
   input  logic [31:0] ram_data_i,
   input  logic        stall_i
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] regs_q [0:31];
   logic [31:0] inst, rs1_v, rs2_v, imm_i, imm_s, imm_u, imm_j, rd_v;
   logic [4:0]  rd;
   logic        rd_we;

   assign inst       = rom_data_i;
   assign rd         = inst[11:7];
   assign rs1_v      = (inst[19:15] == 5'd0) ? ZERO_WORD : regs_q[inst[19:15]];
   assign rs2_v      = (inst[24:20] == 5'd0) ? ZERO_WORD : regs_q[inst[24:20]];
   assign imm_i      = {{20{inst[31]}}, inst[31:20]};
   assign imm_s      = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_u      = {inst[31:12], 12'b0};
   assign imm_j      = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
   assign rom_addr_o = pc_q;
   assign rom_ce_o   = CHIP_ENABLE;

   // Decode/execute of the fetched instruction and data-port request.
   always_comb begin
      pc_d       = pc_q + 32'd4;
      rd_we      = 1'b0;
      rd_v       = ZERO_WORD;
      ram_addr_o = ZERO_WORD;
      ram_ce_o   = CHIP_DISABLE;
      ram_we_o   = 1'b0;
      ram_sel_o  = 4'b0000;
      ram_data_o = ZERO_WORD;
      case (inst[6:0])
         OPC_LUI:   begin rd_we = 1'b1; rd_v = imm_u; end
         OPC_AUIPC: begin rd_we = 1'b1; rd_v = pc_q + imm_u; end
         OPC_JAL:   begin rd_we = 1'b1; rd_v = pc_q + 32'd4; pc_d = pc_q + imm_j; end
         OPC_OPIMM: begin
            rd_we = 1'b1;
            case (inst[14:12])
               3'b000:  rd_v = rs1_v + imm_i;
               3'b010:  rd_v = {31'b0, $signed(rs1_v) < $signed(imm_i)};
               3'b011:  rd_v = {31'b0, rs1_v < imm_i};
               3'b100:  rd_v = rs1_v ^ imm_i;
               3'b110:  rd_v = rs1_v | imm_i;
               3'b111:  rd_v = rs1_v & imm_i;
               3'b001:  rd_v = rs1_v << inst[24:20];
               default: rd_v = inst[30] ? 32'($signed(rs1_v) >>> inst[24:20])
                                        : rs1_v >> inst[24:20];
            endcase
         end
         OPC_LOAD: begin
            rd_we      = 1'b1;
            ram_ce_o   = CHIP_ENABLE;
            ram_addr_o = rs1_v + imm_i;
            ram_sel_o  = 4'b1111;
            rd_v       = ram_data_i;
         end
         OPC_STORE: begin
            ram_ce_o   = CHIP_ENABLE;
            ram_we_o   = WRITE_ENABLE;
            ram_addr_o = rs1_v + imm_s;
            case (inst[13:12])
               2'b00:   begin ram_sel_o = 4'b0001 << ram_addr_o[1:0];
                              ram_data_o = {4{rs2_v[7:0]}}; end
               2'b01:   begin ram_sel_o = 4'b0011 << {ram_addr_o[1], 1'b0};
                              ram_data_o = {2{rs2_v[15:0]}}; end
               default: begin ram_sel_o = 4'b1111; ram_data_o = rs2_v; end
            endcase
         end
         default: ;
      endcase
      if (stall_i) begin
         ram_ce_o = CHIP_DISABLE;
         ram_we_o = 1'b0;
      end
   end

   // Program counter: restart at 0 on reset, hold while stalled.
   always_ff @(posedge clk_i) begin
      if (rst_i == RST_ENABLE) pc_q <= ZERO_WORD;
      else if (!stall_i)       pc_q <= pc_d;
   end

   // Register file write-back; x0 stays zero.
   always_ff @(posedge clk_i) begin
      if (rst_i == RST_DISABLE && !stall_i && rd_we && rd != 5'd0) regs_q[rd] <= rd_v;
   end

endmodule

// File: rtl/rv32ima_soc_inst_rom.sv
// Instruction ROM (module inst_rom). Contents are loaded externally through
// the hierarchical path <top>.rom_0.inst_mem; the array is never written here.
module inst_rom
   import rv32ima_soc_pkg::*;
#(
   parameter int unsigned ROM_DEPTH = 1024
) (
   input  logic                       ce_i,
   input  logic [INST_ADDR_BUS_W-1:0] addr_i,
   output logic [INST_BUS_W-1:0]      inst_o
);

   localparam int AW = $clog2(ROM_DEPTH);

   reg [31:0] inst_mem [0:ROM_DEPTH-1];

   logic       addr_unused;
   assign addr_unused = ^{addr_i[INST_ADDR_BUS_W-1:AW+2], addr_i[1:0]};

   // Word-indexed combinational read; byte offset ignored, upper bits wrap.
   always_comb begin
      inst_o = ZERO_WORD;
      if (ce_i == CHIP_ENABLE) inst_o = inst_mem[addr_i[AW+1:2]];
   end

endmodule

// File: rtl/rv32ima_soc.sv
// SoC top: rv32ima_core + instruction ROM + data RAM + halt register.
// Optional debug outputs are enabled by defining SOC_DEBUG_PORTS_EN.
module rv32ima_soc
   import rv32ima_soc_pkg::*;
#(
   parameter int unsigned ROM_DEPTH = 1024,
   parameter int unsigned RAM_DEPTH = 1024,
   parameter logic [31:0] RAM_BASE  = RAM_BASE_DEF,
   parameter logic [31:0] HALT_ADDR = HALT_ADDR_DEF
) (
   input  logic        clk_i,
   input  logic        rst_i
`ifdef SOC_DEBUG_PORTS_EN
   ,
   output logic [31:0] dbg_pc_o,
   output logic [0:0]  dbg_halt_o,
   output logic [0:0]  dbg_wr_o
`endif
);

   localparam int          RAW      = $clog2(RAM_DEPTH);
   localparam logic [32:0] RAM_SPAN = 33'(RAM_DEPTH) * 33'd4;

   logic [31:0] rom_addr, rom_data, ram_addr, ram_wdata, ram_rdata, ram_offset;
   logic [3:0]  ram_sel;
   logic        rom_ce, ram_ce, ram_we;
   logic        ram_hit, halt_hit, ram_wr_en, halt_wr_en;
   logic        halt_q, halt_d;
   logic [RAW-1:0] ram_idx;
   logic [31:0] ram_mem [0:RAM_DEPTH-1];
   logic        ram_addr_unused;

   rv32ima_core cpu_0 (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .rom_addr_o (rom_addr),
      .rom_ce_o   (rom_ce),
      .rom_data_i (rom_data),
      .ram_addr_o (ram_addr),
      .ram_ce_o   (ram_ce),
      .ram_we_o   (ram_we),
      .ram_sel_o  (ram_sel),
      .ram_data_o (ram_wdata),
      .ram_data_i (ram_rdata),
      .stall_i    (halt_q)
   );

   inst_rom #(.ROM_DEPTH(ROM_DEPTH)) rom_0 (
      .ce_i   (rom_ce),
      .addr_i (rom_addr),
      .inst_o (rom_data)
   );

   // Address decode; writes are blocked during reset.
   always_comb begin
      ram_offset = ram_addr - RAM_BASE;
      ram_idx    = ram_offset[RAW+1:2];
      ram_hit    = (ram_addr >= RAM_BASE) && ({1'b0, ram_offset} < RAM_SPAN);
      halt_hit   = (ram_addr[31:2] == HALT_ADDR[31:2]);
      ram_wr_en  = (rst_i == RST_DISABLE) && ram_ce && ram_we && ram_hit;
      halt_wr_en = (rst_i == RST_DISABLE) && ram_ce && ram_we && halt_hit;
   end

   assign ram_addr_unused = ^{ram_offset[31:RAW+2], ram_offset[1:0]};

   // Read data mux: RAM word, halt word, or zero for unmapped/idle.
   always_comb begin
      ram_rdata = ZERO_WORD;
      if (ram_ce == CHIP_ENABLE) begin
         if (ram_hit)       ram_rdata = ram_mem[ram_idx];
         else if (halt_hit) ram_rdata = {31'b0, halt_q};
      end
   end

   // Byte-lane RAM write; contents survive reset.
   always_ff @(posedge clk_i) begin
      if (ram_wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (ram_sel[i]) ram_mem[ram_idx][8*i +: 8] <= ram_wdata[8*i +: 8];
         end
      end
   end

   // Halt is sticky until reset.
   always_comb begin
      halt_d = halt_q;
      if (halt_wr_en && ram_wdata[0]) halt_d = 1'b1;
   end

   // Halt register; reset wins over a same-cycle halt write.
   always_ff @(posedge clk_i) begin
      if (rst_i == RST_ENABLE) halt_q <= 1'b0;
      else                     halt_q <= halt_d;
   end

`ifdef SOC_DEBUG_PORTS_EN
   // Debug taps, forced to zero while reset is asserted.
   always_comb begin
      dbg_pc_o   = (rst_i == RST_ENABLE) ? ZERO_WORD : rom_addr;
      dbg_halt_o = (rst_i == RST_ENABLE) ? 1'b0 : halt_q;
      dbg_wr_o   = ram_wr_en | halt_wr_en;
   end
`endif

endmodule

// File: tb/tb_rv32ima_soc.sv
// Directed bench for rv32ima_soc: runs a small store/load/halt program from
// the ROM and checks RAM contents, halt behaviour and reset interactions.
module tb_rv32ima_soc;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   chk_cnt = 0;
   int   err_cnt = 0;
   bit   hit;
   int   changes;

   rv32ima_soc dut (
      .clk_i (clk_i),
      .rst_i (rst_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic wait_pc(input logic [31:0] a, input int budget, output bit found);
      found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk_i); #1;
         if (dut.rom_addr == a) found = 1'b1;
      end
   endtask

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] opc);
      return {imm, rs1, f3, rd, opc};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
      return {imm, rd, 7'b0110111};
   endfunction

   localparam logic [6:0] OPIMM = 7'b0010011;
   localparam logic [6:0] LOAD  = 7'b0000011;

   logic [31:0] prog [0:26];

   initial begin
      prog[0]  = enc_i(12'h055, 5'd0, 3'd0, 5'd1, OPIMM); // addi x1,x0,0x55
      prog[1]  = enc_u(20'h10000, 5'd2);                  // lui  x2,0x10000
      prog[2]  = enc_s(12'h000, 5'd1, 5'd2, 3'd2);        // sw   x1,0(x2)
      prog[3]  = enc_u(20'hAABBD, 5'd3);                  // lui  x3,0xAABBD
      prog[4]  = enc_i(12'hCDD, 5'd3, 3'd0, 5'd3, OPIMM); // addi x3,x3,-803
      prog[5]  = enc_s(12'h004, 5'd3, 5'd2, 3'd2);        // sw   x3,4(x2)
      prog[6]  = enc_s(12'h005, 5'd1, 5'd2, 3'd0);        // sb   x1,5(x2)
      prog[7]  = enc_u(20'h20000, 5'd4);                  // lui  x4,0x20000
      prog[8]  = enc_i(12'h000, 5'd4, 3'd2, 5'd5, LOAD);  // lw   x5,0(x4)
      prog[9]  = enc_i(12'h077, 5'd5, 3'd0, 5'd5, OPIMM); // addi x5,x5,0x77
      prog[10] = enc_s(12'h008, 5'd5, 5'd2, 3'd2);        // sw   x5,8(x2)
      prog[11] = enc_u(20'h30000, 5'd6);                  // lui  x6,0x30000
      prog[12] = enc_i(12'hFFF, 5'd0, 3'd0, 5'd7, OPIMM); // addi x7,x0,-1
      prog[13] = enc_i(12'h000, 5'd6, 3'd2, 5'd7, LOAD);  // lw   x7,0(x6)
      prog[14] = enc_i(12'h011, 5'd7, 3'd0, 5'd7, OPIMM); // addi x7,x7,0x11
      prog[15] = enc_s(12'h00C, 5'd7, 5'd2, 3'd2);        // sw   x7,12(x2)
      prog[16] = enc_s(12'h000, 5'd1, 5'd6, 3'd2);        // sw   x1,0(x6)
      prog[17] = enc_u(20'h10001, 5'd8);                  // lui  x8,0x10001
      prog[18] = enc_s(12'h000, 5'd3, 5'd8, 3'd2);        // sw   x3,0(x8)  one past RAM
      prog[19] = enc_i(12'hFFC, 5'd8, 3'd0, 5'd8, OPIMM); // addi x8,x8,-4
      prog[20] = enc_s(12'h000, 5'd3, 5'd8, 3'd2);        // sw   x3,0(x8)  last RAM word
      prog[21] = enc_s(12'h000, 5'd0, 5'd4, 3'd2);        // sw   x0,0(x4)  no halt
      prog[22] = enc_s(12'h010, 5'd1, 5'd2, 3'd2);        // sw   x1,16(x2)
      prog[23] = enc_i(12'h001, 5'd0, 3'd0, 5'd9, OPIMM); // addi x9,x0,1
      prog[24] = enc_s(12'h000, 5'd9, 5'd4, 3'd2);        // sw   x9,0(x4)  halt
      prog[25] = enc_s(12'h000, 5'd9, 5'd2, 3'd2);        // sw   x9,0(x2)  must not run
      prog[26] = 32'h0000_006F;                           // jal  x0,0
      for (int i = 0; i < 27; i++) dut.rom_0.inst_mem[i] = prog[i];

      // Initial reset, then reset asserted while the first store is presented.
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      wait_pc(32'h0000_0008, 20, hit);
      check("pc_reach_first_sw", {31'b0, hit}, 32'd1);
      rst_i = 1'b1; #1;
      check("rst_cycle_wr_en", {31'b0, dut.ram_wr_en}, 32'd0);
      @(negedge clk_i); #1;
      check("rst_cycle_wr_suppressed", {31'b0, dut.ram_mem[0] == 32'h55}, 32'd0);

      repeat (9) @(negedge clk_i); #1;
      check("rst_rom_addr", dut.rom_addr, 32'h0);
      check("rst_halt", {31'b0, dut.halt_q}, 32'd0);
      check("rst_wr_en", {31'b0, dut.ram_wr_en}, 32'd0);

      rst_i = 1'b0; #1;
      check("first_fetch", dut.rom_addr, 32'h0);

      hit = 1'b0;
      for (int i = 0; i < 10 && !hit; i++) begin
         @(negedge clk_i); #1;
         if (dut.ram_mem[0] == 32'h0000_0055) hit = 1'b1;
      end
      check("ram0_store", {31'b0, hit}, 32'd1);

      wait_pc(32'h0000_0060, 100, hit);
      check("pc_reach_halt_sw", {31'b0, hit}, 32'd1);
      check("halt_before", {31'b0, dut.halt_q}, 32'd0);
      @(negedge clk_i); #1;
      check("halt_after", {31'b0, dut.halt_q}, 32'd1);
      check("halt_pc", dut.rom_addr, 32'h0000_0064);
      changes = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_i); #1;
         if (dut.rom_addr != 32'h0000_0064) changes++;
      end
      check("halt_pc_frozen", changes, 32'd0);

      check("ram0", dut.ram_mem[0], 32'h0000_0055);
      check("ram1_sb_lane", dut.ram_mem[1], 32'hAABB_55DD);
      check("ram2_halt_read", dut.ram_mem[2], 32'h0000_0077);
      check("ram3_unmapped_read", dut.ram_mem[3], 32'h0000_0011);
      check("ram4_after_halt0", dut.ram_mem[4], 32'h0000_0055);
      check("ram_last_word", dut.ram_mem[1023], 32'hAABB_CCDD);

      // Long reset after a halted run.
      rst_i = 1'b1;
      repeat (50) @(negedge clk_i); #1;
      check("rst50_halt", {31'b0, dut.halt_q}, 32'd0);
      check("rst50_rom_addr", dut.rom_addr, 32'h0);
      check("rst50_ram0_kept", dut.ram_mem[0], 32'h0000_0055);
      rst_i = 1'b0; #1;
      check("restart_fetch", dut.rom_addr, 32'h0);
      @(negedge clk_i); #1;
      check("restart_advance", dut.rom_addr, 32'h4);

      // Reset coincident with the halt store.
      wait_pc(32'h0000_0060, 100, hit);
      check("pc_reach_halt_sw2", {31'b0, hit}, 32'd1);
      rst_i = 1'b1;
      @(negedge clk_i); #1;
      check("rst_beats_halt", {31'b0, dut.halt_q}, 32'd0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no end, want end of test");
      $fatal(1);
   end

endmodule

// File: doc/rv32ima_soc.md
Name: rv32ima_soc

Overview:
- SoC top wrapper that ties the team's existing RV32IMA pipeline core (module rv32ima_core, instance cpu_0) to an instruction ROM, a data RAM and a halt register.
- Provides the address decode, byte-lane write logic and stall control for a single-core, single-clock simulation/FPGA target.
- Has no functional outputs; programs are preloaded into the ROM, and results are observed in RAM or the halt register.

Parameters:
- ROM_DEPTH, 1024: instruction ROM size in 32-bit words (power of two).
- RAM_DEPTH, 1024: data RAM size in 32-bit words (power of two).
- RAM_BASE, 32'h1000_0000: data RAM base address.
- HALT_ADDR, 32'h2000_0000: halt register address.

Ports:
- clk_i  input  1  single system clock, rising edge.
- rst_i  input  1  synchronous active-high reset (RstEnable = 1'b1 in define.v).

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high, sampled on the rising edge of clk_i.
  - rst_i is passed straight to cpu_0.
- Core port contract (rv32ima_core): clk_i, rst_i, rom_addr_o[31:0], rom_ce_o, rom_data_i[31:0], ram_addr_o[31:0], ram_ce_o, ram_we_o, ram_sel_o[3:0], ram_data_o[31:0], ram_data_i[31:0], stall_i.
  - The core fetches from reset PC 0x0000_0000.
  - AMO/LR/SC are resolved inside the core as read-then-write sequences on the data port.
- Instruction ROM:
  - Submodule instance rom_0 holding array reg [31:0] inst_mem[0:ROM_DEPTH-1].
  - Must stay reachable by hierarchical path <top>.rom_0.inst_mem for $readmemb loading, one 32-bit binary word per line.
  - Read is combinational: rom_data_i = inst_mem[rom_addr_o[log2(ROM_DEPTH)+1:2]] when rom_ce_o = 1, else 32'h0.
  - Address bits [1:0] are ignored. Higher bits wrap modulo ROM_DEPTH.
  - The ROM is never written.
- Data decode: select = ram_ce_o.
  - RAM hit: ram_addr_o in [RAM_BASE, RAM_BASE + 4*RAM_DEPTH).
  - Halt hit: ram_addr_o[31:2] == HALT_ADDR[31:2].
  - Everything else is unmapped.
- Data RAM:
  - Combinational word read.
  - Synchronous write on the rising edge when select, ram_we_o and RAM hit are all true.
  - Only byte lanes with ram_sel_o[i] = 1 are updated (lane 0 = bits 7:0, little-endian).
  - Contents are not cleared by reset.
- Halt register:
  - 1-bit halt_q, reset to 0.
  - A write to HALT_ADDR with ram_data_o[0] = 1 sets it; it is cleared only by reset.
  - A read returns {31'b0, halt_q}.
- Stall: stall_i = halt_q.
  - While halted the core's PC and architectural state freeze; ROM fetch continues at the frozen address.
- Unmapped accesses: reads return 32'h0; writes are ignored. No exception is raised.
- Read data mux:
  - ram_data_i = RAM word on RAM hit, halt word on halt hit, else 0.
  - ram_data_i is 0 when ram_ce_o = 0.
- Simultaneous events:
  - Reset takes priority over a same-cycle halt write; halt_q ends at 0.
  - A RAM write in the reset cycle is suppressed.
- Reset mid-run: the core restarts at PC 0 and halt_q clears; RAM keeps its contents.

Optional Feature:
- Macro SOC_DEBUG_PORTS_EN.
- When defined, the top adds outputs:
  - dbg_pc_o [31:0]: equals rom_addr_o.
  - dbg_halt_o [0:0]: equals halt_q.
  - dbg_wr_o [0:0]: 1 in any cycle that commits a RAM or halt write.
  - All three are 0 during reset.
- When undefined, these ports and their logic are absent and the port list is exactly clk_i, rst_i.

Decomposition:
- Shared package/define file (define.v): RstEnable/RstDisable, ChipEnable/ChipDisable, WriteEnable, ZeroWord, InstBus and InstAddrBus widths, and the default RAM_BASE and HALT_ADDR constants.
- One natural submodule: inst_rom (instance rom_0).
- Data RAM and decode stay inline in the top.

Test Plan:
- Hold rst_i = 1 for 10 cycles -> rom_addr_o = 0, halt_q = 0, no RAM write; after release the first fetch is address 0x0.
- Program "addi x1,x0,0x55; lui x2,0x10000; sw x1,0(x2)" -> RAM word 0 = 0x0000_0055 within 10 cycles of the store issuing.
- Preload RAM word 1 = 0xAABBCCDD; execute "sb x1,5(x2)" with x1 = 0x55 -> word 1 = 0xAABB55DD, other lanes unchanged.
- Store 1 to 0x2000_0000 -> halt_q = 1 next edge; rom_addr_o constant for the next 20 cycles; lw from 0x2000_0000 before the halt returns 0.
- Reassert rst_i for 50 cycles after a halted run -> halt_q = 0, fetch restarts at 0x0, RAM word 0 still 0x55.
- lw from 0x3000_0000 -> loads 0; sw to 0x3000_0000 -> no RAM or halt change.
